posit_result_streamer: RTL
==========================

# posit_result_streamer

Downstream stage of the 32-bit posit multiplier. Captures each product with its `error`/`zero` flags through a valid/ready handshake and buffers it in a small FIFO. It then streams each result out MSB-first as 8-bit bytes on a second valid/ready handshake. It replaces the static 16-bit output view with a back-pressured byte stream suitable for a narrow host interface.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `NAR_WORD`, 32'h8000_0000: word substituted for a result flagged `error`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `res_valid`, input, 1: multiplier result present.
- `res_ready`, output, 1: streamer accepts a result this cycle.
- `res_product`, input, 32: posit product; ignored when `res_error`=1.
- `res_error`, input, 1: regime overflow/underflow flag.
- `res_zero`, input, 1: zero-operand flag.
- `byte_valid`, output, 1: `byte_data` is valid.
- `byte_ready`, input, 1: consumer accepts a byte.
- `byte_data`, output, 8: current byte; 0 when `byte_valid`=0.
- `byte_last`, output, 1: current byte is the final byte of its result.
- `fill`, output, $clog2(DEPTH)+1: number of occupied FIFO entries.

## Operation
- Push: when `res_valid && res_ready`, write one entry. The entry holds the word and the flags.
  - Word stored: `NAR_WORD` if `res_error`; 32'h0 if `res_zero` and not `res_error`; otherwise `res_product`.
  - `res_error` has priority over `res_zero`.
- `res_ready` = (`fill` < DEPTH). Data is never dropped. A push is refused when full, even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: `fill`=0, `byte_valid`=0. Moves to SEND on the cycle after a push.
  - SEND: `byte_valid`=1 and presents byte `idx` of the head entry.
    - On a `byte_valid && byte_ready` handshake, `idx` increments.
    - On the handshake of the last byte, pop the head and clear `idx` to 0. Stay in SEND if the FIFO is non-empty after the pop; otherwise go to IDLE.
- Byte order without status: `idx` 0..3 maps to word[31:24], [23:16], [15:8], [7:0].
- `byte_last`=1 only on the final `idx` while in SEND.
- Simultaneous push and pop: `fill` is unchanged. Both happen in the same cycle.
- `byte_data`, `byte_valid` and `byte_last` hold stable while `byte_valid && !byte_ready`.
- Reset mid-stream: the partial result is discarded. No resumption.

## Timing
- Reset values: `res_ready`=1, `byte_valid`=0, `byte_data`=0, `byte_last`=0, `fill`=0, FSM=IDLE, `idx`=0, FIFO pointers 0.
- Latency: a result pushed at edge N drives `byte_valid`=1 with byte 0 from edge N+1 when the FIFO was empty.
- Throughput: one byte per cycle with `byte_ready` held high. This gives 4 cycles per result, or 5 with status.
  - Back-to-back results have no bubble.
- `byte_*` and `res_ready` are driven only from registers. There is no combinational path from `byte_ready` or `res_valid` to any output.
- `fill` updates on the edge of a push and/or pop.

## Configuration
- `POSIT_STREAM_STATUS_EN` defined:
  - Each result is preceded by a status byte {6'b0, error, zero} at `idx` 0.
  - The product bytes follow at `idx` 1..4. `byte_last` is at `idx` 4.
  - The flags are stored in the FIFO entry (34-bit entry).
- `POSIT_STREAM_STATUS_EN` undefined:
  - 4 bytes per result, `byte_last` at `idx` 3.
  - Entries are 32-bit. The flags only affect the substituted word.

## Structure
- Package `posit_stream_pkg` holds:
  - The FSM state enum (IDLE, SEND).
  - `BYTES_PER_RESULT`, set by the macro.
  - The default `NAR_WORD`.
  - The entry typedef {word, error, zero}.
- One sub-module, `posit_result_fifo`: synchronous FIFO of DEPTH entries.
  - Single clock, asynchronous active-low reset.
  - Exports full, empty and count.
  - Pointers wrap modulo DEPTH.
- The top level contains the substitution logic, the FSM, `idx` and the byte mux.

## Test plan
- Reset, then push product 32'h4A3C_1122 with flags 0 and `byte_ready`=1.
  - Expect bytes 4A, 3C, 11, 22 on cycles 1–4 after the push, `byte_last` on 22, then `byte_valid`=0 and `fill`=0.
- Push with `res_error`=1 and `res_product`=X.
  - Expect bytes 80, 00, 00, 00; with the macro, status byte 02 first.
- Push with `res_zero`=1 and `res_product`=32'h1234_5678.
  - Expect 00, 00, 00, 00; with the macro, status 01 first.
- `byte_ready`=0, push DEPTH+1 results.
  - Expect `res_ready`=0 after DEPTH pushes and `fill`=DEPTH.
  - Then release `byte_ready`: all DEPTH results stream in order, and the refused result is accepted once `res_ready` returns to 1.
- Toggle `byte_ready` randomly each cycle during a 3-result burst.
  - Expect `byte_data` stable while stalled and no byte lost or duplicated.
- Assert `reset` low after the second byte of a result.
  - Expect all outputs at their reset values asynchronously.
  - The next pushed result streams from byte 0.

Source files
------------

// File: rtl/posit_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : posit_stream_pkg
//  Description : Shared types and constants for the posit result streamer.
//                Holds the FSM state enum, the FIFO entry type, the number
//                of bytes streamed per result and the default NaR word.
//  Macro       : POSIT_STREAM_STATUS_EN - when defined, a status byte
//                {6'b0, error, zero} precedes each product, and the flags
//                are stored in every FIFO entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package posit_stream_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

`ifdef POSIT_STREAM_STATUS_EN
  localparam int BYTES_PER_RESULT = 5;

  typedef struct packed {
    logic [31:0] word;
    logic        error;
    logic        zero;
  } entry_t;
`else
  localparam int BYTES_PER_RESULT = 4;

  // Without the status byte the flags only shape the stored word.
  typedef struct packed {
    logic [31:0] word;
  } entry_t;
`endif

  localparam logic [31:0] DEFAULT_NAR_WORD = 32'h8000_0000;

  // Byte index width; covers up to 8 bytes per result.
  localparam int IDX_W = 3;

endpackage : posit_stream_pkg
`default_nettype wire

// File: rtl/posit_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : posit_result_fifo
//  Description : Synchronous FIFO of DEPTH result entries. Single clock,
//                asynchronous active-low reset. Pointers wrap modulo DEPTH.
//                The head entry is always visible on rdata_o.
//  Ports       : clk      - clock
//                reset_ni - asynchronous active-low reset
//                push_i   - write wdata_i (ignored when full)
//                wdata_i  - entry to write
//                pop_i    - drop the head entry (ignored when empty)
//                rdata_o  - head entry
//                full_o   - count_o == DEPTH
//                empty_o  - count_o == 0
//                count_o  - number of occupied entries
//  Macro       : POSIT_STREAM_STATUS_EN (via entry_t width)
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_result_fifo
  import posit_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_ni,
  input  logic                     push_i,
  input  entry_t                   wdata_i,
  input  logic                     pop_i,
  output entry_t                   rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               wr_en;
  logic               rd_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against overflow/underflow locally so the FIFO is safe on its own.
  assign wr_en = push_i & ~full_o;
  assign rd_en = pop_i  & ~empty_o;

  // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : posit_result_fifo
`default_nettype wire

// File: rtl/posit_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : posit_result_streamer
//  Description : Captures posit multiplier results (word + error/zero flags)
//                on a valid/ready handshake, buffers them in a FIFO and
//                streams each one MSB-first as bytes on a second valid/ready
//                handshake. Error results are replaced by NAR_WORD, zero
//                results by 32'h0 (error wins over zero).
//  Ports       : clk         - clock, rising edge
//                reset       - asynchronous active-low reset
//                res_valid   - result present
//                res_ready   - result accepted this cycle (FIFO not full)
//                res_product - posit product (ignored when res_error)
//                res_error   - regime overflow/underflow flag
//                res_zero    - zero-operand flag
//                byte_valid  - byte_data valid
//                byte_ready  - consumer accepts a byte
//                byte_data   - current byte, 0 when idle
//                byte_last   - final byte of the current result
//                fill        - occupied FIFO entries
//  Macro       : POSIT_STREAM_STATUS_EN - prepend status byte
//                {6'b0, error, zero} to each result (5 bytes per result).
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_result_streamer
  import posit_stream_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NAR_WORD = DEFAULT_NAR_WORD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [31:0]            res_product,
  input  logic                   res_error,
  input  logic                   res_zero,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [7:0]             byte_data,
  output logic                   byte_last,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int             CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_RESULT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  entry_t           push_entry;
  entry_t           head_entry;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       byte_mux;

  // ---------------------------------------------------------------------------
  // Input side: substitution of special words
  // ---------------------------------------------------------------------------
  assign res_ready = ~fifo_full;
  assign push      = res_valid & res_ready;

  always_comb begin
    push_entry = '0;
    if (res_error)     push_entry.word = NAR_WORD;
    else if (res_zero) push_entry.word = 32'h0;
    else               push_entry.word = res_product;
`ifdef POSIT_STREAM_STATUS_EN
    push_entry.error = res_error;
    push_entry.zero  = res_zero;
`endif
  end

  posit_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_ni (reset),
    .push_i   (push),
    .wdata_i  (push_entry),
    .pop_i    (pop),
    .rdata_o  (head_entry),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign fill = fifo_count;

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        // Entering SEND one edge after the push keeps outputs register-driven.
        if (!fifo_empty) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (byte_ready) begin
          if (idx_q == LAST_IDX) begin
            pop   = 1'b1;
            idx_d = '0;
            // A push landing on the same edge keeps the stream bubble-free.
            if ((fifo_count <= CNT_W'(1)) && !push) state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte mux over the head entry
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_mux = 8'h00;
    if (state_q == ST_SEND) begin
      unique case (idx_q)
`ifdef POSIT_STREAM_STATUS_EN
        3'd0:    byte_mux = {6'b0, head_entry.error, head_entry.zero};
        3'd1:    byte_mux = head_entry.word[31:24];
        3'd2:    byte_mux = head_entry.word[23:16];
        3'd3:    byte_mux = head_entry.word[15:8];
        3'd4:    byte_mux = head_entry.word[7:0];
`else
        3'd0:    byte_mux = head_entry.word[31:24];
        3'd1:    byte_mux = head_entry.word[23:16];
        3'd2:    byte_mux = head_entry.word[15:8];
        3'd3:    byte_mux = head_entry.word[7:0];
`endif
        default: byte_mux = 8'h00;
      endcase
    end
  end

  assign byte_valid = (state_q == ST_SEND);
  assign byte_data  = byte_mux;
  assign byte_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);

endmodule : posit_result_streamer
`default_nettype wire
